exec_issue_ctrl: RTL
====================

# exec_issue_ctrl

In-order issue controller between the decoder and the execute datapath. It accepts one decoded instruction per cycle over a valid/ready handshake and steers it to one of two units: the single-cycle ALU or the non-pipelined multi-cycle mul/div unit. A one-entry-per-register scoreboard tracks the outstanding mul/div destination and stalls dependent instructions. The block also arbitrates the single GPR write port between ALU and mul/div results.

## Interface
- NREG, 32, number of GPRs; x0 is hardwired zero and never pending
- RW, 5, register index width ($clog2(NREG))
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle (issue = in_valid & in_ready)
- in_rd / in_rs1 / in_rs2  in  RW  register indices
- in_uses_rs1 / in_uses_rs2 / in_writes_rd  in  1  operand/destination usage flags
- in_is_md  in  1  instruction is mul/mulh*/div*/rem* class
- alu_go  out  1  ALU executes the issued instruction this cycle
- md_start  out  1  start pulse to the mul/div unit
- md_done  in  1  one-cycle pulse: mul/div result valid
- wb_en  out  1  GPR write enable
- wb_rd  out  RW  GPR write index
- wb_sel  out  1  0 = ALU result, 1 = mul/div result

## Operation
- FSM states: IDLE (no mul/div op outstanding), MD_BUSY (waiting for md_done), MD_WB (mul/div writeback cycle).
- Transitions: IDLE→MD_BUSY on an md issue. MD_BUSY→MD_WB on md_done. MD_WB→MD_BUSY on an md issue, else MD_WB→IDLE.
- Hazard, raised when the pending register p is nonzero:
  - (in_uses_rs1 & in_rs1==p), or
  - (in_uses_rs2 & in_rs2==p), or
  - (in_writes_rd & in_rd==p).
  - Index-0 operands never hazard.
- in_ready = !reset & !hazard & !(state==MD_BUSY & (in_is_md | md_done)).
  - No instruction of any kind issues in the md_done cycle.
- alu_go = issue & !in_is_md; md_start = issue & in_is_md. Both are combinational, in the issue cycle.
- On md issue with in_writes_rd & in_rd≠0:
  - latch md_rd = in_rd;
  - set the pending bit on the edge ending the issue cycle.
  - Otherwise md_rd is latched as 0 and nothing is set pending.
- Pending bit clears on the edge ending MD_WB.
- md_done outside MD_BUSY is ignored: no state change, no writeback.

## Timing
- Reset values: state IDLE, scoreboard all clear, md_rd=0, wb_en=0, wb_rd=0, wb_sel=0. in_ready, alu_go and md_start are 0 while reset is high.
- ALU instruction issued in cycle N: wb_en=in_writes_rd&(in_rd≠0), wb_rd=in_rd, wb_sel=0, all registered, in cycle N+1.
- Mul/div issued in cycle N:
  - state MD_BUSY from N+1; md_done earliest at N+1.
  - md_done at cycle D: MD_WB in D+1 with wb_en=(md_rd≠0), wb_rd=md_rd, wb_sel=1.
  - Earliest dependent issue is D+2.
- Independent ALU/md instructions may issue in MD_WB. Their writeback lands at MD_WB+1, so there is no write-port conflict.
- Write-port exclusivity is guaranteed: wb_sel=1 cycles never coincide with ALU writebacks.
- Reset asserted mid-operation (any state): clears the scoreboard and returns the FSM to IDLE next edge. A late md_done is then ignored.
- Throughput: 1 ALU instruction per cycle when hazard-free.

## Configuration
- EXEC_PERF_CNT_EN defined: adds output ports perf_issue_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_issue_cnt counts issue cycles.
  - perf_stall_cnt counts cycles with in_valid & !in_ready.
  - Both reset to 0 and wrap at 2^32.
- EXEC_PERF_CNT_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package exec_pkg holds:
  - NREG / RW constants;
  - typedef reg_idx_t (logic [RW-1:0]);
  - enum exec_state_e {IDLE, MD_BUSY, MD_WB};
  - enum wb_sel_e {WB_ALU=0, WB_MD=1}.
- Sub-module exec_scoreboard: NREG-bit pending vector with set/clear ports and a combinational 3-index hazard lookup. x0 is masked.

## Test plan
- Reset, then an ALU stream: addi x5 in cycle 3 and add x6 in cycle 4 → alu_go both cycles; wb_en with wb_rd=5 in cycle 4 and wb_rd=6 in cycle 5; wb_sel=0.
- Mul x7 issued in cycle 10, md_done in cycle 14, then dependent add x8,x7,x1 held valid → in_ready=0 in cycles 11–15; wb_rd=7 with wb_sel=1 in cycle 15; add issues in cycle 16.
- Mul x7 outstanding with an independent and x9,x2,x3 → the and issues during MD_BUSY; a second div is refused until MD_WB, where it is accepted with md_start=1.
- md_done asserted in cycle 20 with a valid independent ALU instruction → in_ready=0 in cycle 20, issue in cycle 21; no cycle has two writes.
- Div with rd=x0 → no pending bit set; MD_WB has wb_en=0; an instruction using x0 as rs1 issues immediately.
- Reset asserted in MD_BUSY, then md_done two cycles later → state IDLE, wb_en stays 0. With EXEC_PERF_CNT_EN defined, both counters read 0 after reset.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute issue controller.
// Optional build macro used by the top: EXEC_PERF_CNT_EN.
package exec_pkg;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  typedef logic [RW-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_WB   = 2'd2
  } exec_state_e;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MD  = 1'b1
  } wb_sel_e;
endpackage

// File: rtl/exec_scoreboard.sv
// Per-register pending bits for the outstanding mul/div destination, with a
// combinational hazard lookup on rs1/rs2/rd. x0 never reports pending.
module exec_scoreboard
  import exec_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  input  reg_idx_t rd,
  input  logic     uses_rs1,
  input  logic     uses_rs2,
  input  logic     writes_rd,
  output logic     hazard
);
  logic [NREG-1:0] pend;

  // Clear first, set second: a new md issued in the writeback cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      if (clr_en) pend[clr_idx] <= 1'b0;
      if (set_en) pend[set_idx] <= 1'b1;
      pend[0] <= 1'b0;
    end
  end

  // Any used operand index that is pending blocks issue; index 0 is masked.
  always_comb begin
    hazard = 1'b0;
    if (uses_rs1  && (rs1 != '0) && pend[rs1]) hazard = 1'b1;
    if (uses_rs2  && (rs2 != '0) && pend[rs2]) hazard = 1'b1;
    if (writes_rd && (rd  != '0) && pend[rd])  hazard = 1'b1;
  end
endmodule

// File: rtl/exec_issue_ctrl.sv
// In-order issue controller: steers decoded instructions to ALU or mul/div,
// stalls on the outstanding mul/div destination, and owns the GPR write port.
// Build option: define EXEC_PERF_CNT_EN to add issue/stall performance counters.
module exec_issue_ctrl
  import exec_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rd,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic          in_uses_rs1,
  input  logic          in_uses_rs2,
  input  logic          in_writes_rd,
  input  logic          in_is_md,
  output logic          alu_go,
  output logic          md_start,
  input  logic          md_done,
  output logic          wb_en,
  output logic [RW-1:0] wb_rd,
`ifdef EXEC_PERF_CNT_EN
  output logic [31:0]   perf_issue_cnt,
  output logic [31:0]   perf_stall_cnt,
`endif
  output logic          wb_sel
);
  exec_state_e state_q, state_d;
  reg_idx_t    md_rd_q;
  wb_sel_e     wb_sel_q;
  logic        hazard;
  logic        issue;
  logic        md_ret;
  logic        md_has_rd;

  // A result returning this cycle owns next cycle's write port.
  assign md_ret    = (state_q == MD_BUSY) && md_done;
  assign md_has_rd = in_writes_rd && (in_rd != '0);

  exec_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (md_start && md_has_rd),
    .set_idx   (in_rd),
    .clr_en    (state_q == MD_WB),
    .clr_idx   (md_rd_q),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .rd        (in_rd),
    .uses_rs1  (in_uses_rs1),
    .uses_rs2  (in_uses_rs2),
    .writes_rd (in_writes_rd),
    .hazard    (hazard)
  );

  // The return cycle is blocked for everything so the ALU never collides
  // with the mul/div writeback on the single write port.
  always_comb begin
    in_ready = !reset && !hazard && !((state_q == MD_BUSY) && (in_is_md || md_done));
    issue    = in_valid && in_ready;
    alu_go   = issue && !in_is_md;
    md_start = issue && in_is_md;
  end

  // Next-state for the single outstanding mul/div operation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md_start) state_d = MD_BUSY;
      MD_BUSY: if (md_done)  state_d = MD_WB;
      MD_WB:   state_d = md_start ? MD_BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched mul/div destination.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      md_rd_q <= '0;
    end else begin
      state_q <= state_d;
      if (md_start) md_rd_q <= md_has_rd ? in_rd : '0;
    end
  end

  // Registered write-port control; md return and ALU issue are exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en    <= 1'b0;
      wb_rd    <= '0;
      wb_sel_q <= WB_ALU;
    end else if (md_ret) begin
      wb_en    <= (md_rd_q != '0);
      wb_rd    <= md_rd_q;
      wb_sel_q <= WB_MD;
    end else if (alu_go) begin
      wb_en    <= md_has_rd;
      wb_rd    <= in_rd;
      wb_sel_q <= WB_ALU;
    end else begin
      wb_en    <= 1'b0;
    end
  end

  assign wb_sel = wb_sel_q;

`ifdef EXEC_PERF_CNT_EN
  // Free-running issue and stall counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue)                  perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (in_valid && !in_ready)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
